// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM requester ports and shared memory bus
// bundled for the IF/MEM memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic [DATA_W-1:0]   if_rdata;
  logic                if_ack;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;
  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic [DATA_W-1:0]   bus_rdata;
  logic                bus_ack;
  logic                stall;
  logic                timeout_err;

  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    input  bus_rdata, bus_ack,
    output if_rdata, if_ack,
    output mem_rdata, mem_ack,
    output bus_req, bus_we, bus_addr,
    output bus_wdata, bus_wstrb,
    output stall, timeout_err
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    output bus_rdata, bus_ack,
    input  if_rdata, if_ack,
    input  mem_rdata, mem_ack,
    input  bus_req, bus_we, bus_addr,
    input  bus_wdata, bus_wstrb,
    input  stall, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM requests onto one
// req/ack memory bus with starvation guard and bus timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master p
);
  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_IF,
    GRANT_MEM,
    RESP_IF,
    RESP_MEM
  } state_t;

  state_t state, state_d;

  logic [3:0]        starve, starve_d;
  logic [15:0]       wait_cnt, wait_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] mem_rd_q, mem_rd_d;
  logic              terr_q, terr_d;
  logic [DATA_W-1:0] rd;
  logic              done;
  logic              mem_go;

  // MEM wins ties unless IF has waited out STARVE_LIM MEM grants
  assign mem_go = p.mem_req
                & ~(p.if_req & (starve == 4'(STARVE_LIM)));

  always_comb begin
    state_d   = state;
    starve_d  = starve;
    wait_d    = '0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if_ack_d  = 1'b0;
    mem_ack_d = 1'b0;
    if_rd_d   = '0;
    mem_rd_d  = '0;
    terr_d    = terr_q;
    rd        = '0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_go) begin
          state_d = GRANT_MEM;
          req_d   = 1'b1;
          we_d    = p.mem_we;
          addr_d  = p.mem_addr;
          wdata_d = p.mem_we ? p.mem_wdata : '0;
          wstrb_d = p.mem_we ? p.mem_wstrb : '0;
          if (p.if_req && starve != 4'(STARVE_LIM))
            starve_d = starve + 4'd1;
        end else if (p.if_req) begin
          state_d  = GRANT_IF;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = p.if_addr;
          wdata_d  = '0;
          wstrb_d  = '0;
          starve_d = '0;
        end
      end
      GRANT_IF, GRANT_MEM: begin
        wait_d = wait_cnt + 16'd1;
        done   = p.bus_ack
               | (wait_cnt == 16'(TIMEOUT - 1));
        if (done) begin
          wait_d  = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
          terr_d  = terr_q | ~p.bus_ack;
          rd = (p.bus_ack & ~we_q) ? p.bus_rdata : '0;
          if (state == GRANT_IF) begin
            state_d  = RESP_IF;
            if_ack_d = 1'b1;
            if_rd_d  = rd;
          end else begin
            state_d   = RESP_MEM;
            mem_ack_d = 1'b1;
            mem_rd_d  = rd;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      starve    <= '0;
      wait_cnt  <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      if_rd_q   <= '0;
      mem_rd_q  <= '0;
      terr_q    <= 1'b0;
    end else begin
      state     <= state_d;
      starve    <= starve_d;
      wait_cnt  <= wait_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      if_ack_q  <= if_ack_d;
      mem_ack_q <= mem_ack_d;
      if_rd_q   <= if_rd_d;
      mem_rd_q  <= mem_rd_d;
      terr_q    <= terr_d;
    end
  end

  assign p.bus_req     = req_q;
  assign p.bus_we      = we_q;
  assign p.bus_addr    = addr_q;
  assign p.bus_wdata   = wdata_q;
  assign p.bus_wstrb   = wstrb_q;
  assign p.if_ack      = if_ack_q;
  assign p.if_rdata    = if_rd_q;
  assign p.mem_ack     = mem_ack_q;
  assign p.mem_rdata   = mem_rd_q;
  assign p.timeout_err = terr_q;
  assign p.stall = (p.if_req & ~if_ack_q)
                 | (p.mem_req & ~mem_ack_q);
endmodule
